// File: rtl/cpu.sv
// cpu: multicycle 16-bit simple RISC core with control FSM, 8x16 register file, shifter, ALU and status flags
module cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        N,
  output logic        V,
  output logic        Z,
  output logic        w
);
  typedef enum logic [2:0] {S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WB} state_t;
  state_t      r_state;
  logic [15:0] r_ir, r_a, r_b, r_c;
  logic [15:0] r_regs [8];
  logic        r_n, r_v, r_z;
  logic [2:0]  w_op, w_rn, w_rd, w_rm;
  logic [1:0]  w_sub, w_sh;
  logic [15:0] w_sx, w_bsh, w_ain, w_sum, w_diff, w_alu;
  logic        w_cmp, w_movi, w_getb, w_geta, w_v;
  assign w_op   = r_ir[15:13];
  assign w_sub  = r_ir[12:11];
  assign w_rn   = r_ir[10:8];
  assign w_rd   = r_ir[7:5];
  assign w_sh   = r_ir[4:3];
  assign w_rm   = r_ir[2:0];
  assign w_sx   = {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_movi = (w_op == 3'b110) && (w_sub == 2'b10);
  assign w_getb = ((w_op == 3'b110) && (w_sub == 2'b00)) || ((w_op == 3'b101) && (w_sub == 2'b11));
  assign w_geta = (w_op == 3'b101) && !w_getb;
  assign w_cmp  = (w_op == 3'b101) && (w_sub == 2'b01);
  // shift the B operand by one place according to the sh field
  always_comb
    w_bsh = (w_sh == 2'b01) ? {r_b[14:0], 1'b0} :
            (w_sh == 2'b10) ? {1'b0, r_b[15:1]} :
            (w_sh == 2'b11) ? {r_b[15], r_b[15:1]} : r_b;
  // MOV-by-shift is an ADD with a zero A operand, so stale A never leaks into the result
  assign w_ain  = (w_op == 3'b110) ? 16'h0000 : r_a;
  assign w_sum  = w_ain + w_bsh;
  assign w_diff = r_a - w_bsh;
  assign w_v    = (r_a[15] != w_bsh[15]) && (w_diff[15] != r_a[15]);
  // ALU result select; only ADD/MOV-shift, AND and MVN reach C
  always_comb
    w_alu = (w_op != 3'b101 || w_sub == 2'b00) ? w_sum :
            (w_sub == 2'b10) ? (r_a & w_bsh) :
            (w_sub == 2'b11) ? ~w_bsh : w_diff;
  // control FSM with IR, operand, result, status and register-file updates
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      if (load) r_ir <= in;
      case (r_state)
        S_WAIT:   if (s) r_state <= S_DECODE;
        S_DECODE: r_state <= w_movi ? S_WIMM : w_getb ? S_GETB : w_geta ? S_GETA : S_WAIT;
        S_WIMM: begin
          r_regs[w_rn] <= w_sx;
          r_state      <= S_WAIT;
        end
        S_GETA: begin
          r_a     <= r_regs[w_rn];
          r_state <= S_GETB;
        end
        S_GETB: begin
          r_b     <= r_regs[w_rm];
          r_state <= S_EXEC;
        end
        S_EXEC:
          if (w_cmp) begin
            r_z     <= (w_diff == 16'h0000);
            r_n     <= w_diff[15];
            r_v     <= w_v;
            r_state <= S_WAIT;
          end else begin
            r_c     <= w_alu;
            r_state <= S_WB;
          end
        S_WB: begin
          r_regs[w_rd] <= r_c;
          r_state      <= S_WAIT;
        end
        default:  r_state <= S_WAIT;
      endcase
    end
  assign out = r_c;
  assign N   = r_n;
  assign V   = r_v;
  assign Z   = r_z;
  assign w   = (r_state == S_WAIT);
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: table-driven scoreboard bench for the multicycle cpu
module tb_cpu;
  logic        clk = 1'b0, reset = 1'b1, s = 1'b0, load = 1'b0;
  logic [15:0] in = '0, out;
  logic        N, V, Z, w;
  cpu dut (.clk(clk), .reset(reset), .s(s), .load(load), .in(in), .out(out), .N(N), .V(V), .Z(Z), .w(w));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] instr;
    int          lat;
    bit          chk_out;
    logic [15:0] exp_out;
    bit          chk_f;
    logic [2:0]  exp_f;
  } rec_t;
  rec_t vec[$];
  rec_t sb[$];
  int   checks = 0, fails = 0;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] mi(input logic [2:0] rn, input logic [7:0] im);
    return {3'b110, 2'b10, rn, im};
  endfunction
  function automatic logic [15:0] ms(input logic [2:0] rd, input logic [2:0] rm, input logic [1:0] sh);
    return {3'b110, 2'b00, 3'b000, rd, sh, rm};
  endfunction
  function automatic logic [15:0] al(input logic [1:0] sub, input logic [2:0] rn, input logic [2:0] rd,
                                     input logic [2:0] rm, input logic [1:0] sh);
    return {3'b101, sub, rn, rd, sh, rm};
  endfunction
  function automatic void v(input logic [15:0] instr, input int lat, input bit co, input logic [15:0] eo,
                            input bit cf, input logic [2:0] ef);
    rec_t r;
    r.instr = instr; r.lat = lat; r.chk_out = co; r.exp_out = eo; r.chk_f = cf; r.exp_f = ef;
    vec.push_back(r);
  endfunction
  task automatic run(input logic [15:0] instr, output int n);
    @(negedge clk); in = instr; load = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b1;
    @(negedge clk); s = 1'b0;
    n = 0;
    while (!w && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int   n;
    rec_t e;
    v(mi(1, 8'd13), 2, 0, 0, 0, 0);
    v(mi(2, 8'd5), 2, 0, 0, 0, 0);
    v(al(2'b10, 1, 3, 2, 0), 5, 1, 16'h0005, 0, 0);
    v(ms(0, 3, 0), 4, 1, 16'h0005, 0, 0);
    v(mi(1, 8'd1), 2, 0, 0, 0, 0);
    v(mi(2, 8'd2), 2, 0, 0, 0, 0);
    v(al(2'b00, 1, 5, 2, 2'b01), 5, 1, 16'h0005, 0, 0);
    v(mi(6, 8'd8), 2, 0, 0, 0, 0);
    v(al(2'b00, 2, 7, 6, 2'b10), 5, 1, 16'h0006, 0, 0);
    v(mi(1, 8'hFF), 2, 0, 0, 0, 0);
    v(mi(2, 8'hFF), 2, 0, 0, 0, 0);
    v(al(2'b01, 1, 0, 2, 0), 4, 1, 16'h0006, 1, 3'b100);
    v(mi(1, 8'd3), 2, 0, 0, 0, 0);
    v(mi(2, 8'd6), 2, 0, 0, 0, 0);
    v(al(2'b01, 1, 0, 2, 0), 4, 0, 0, 1, 3'b010);
    v(mi(1, 8'd1), 2, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) v(ms(1, 1, 2'b01), 4, 1, 16'h0002 << k, 0, 0);
    v(mi(2, 8'd1), 2, 0, 0, 0, 0);
    v(al(2'b01, 1, 0, 2, 0), 4, 1, 16'h8000, 1, 3'b001);
    v(ms(3, 1, 2'b11), 4, 1, 16'hC000, 0, 0);
    v(ms(3, 1, 2'b10), 4, 1, 16'h4000, 0, 0);
    v(mi(1, 8'd2), 2, 0, 0, 0, 0);
    v(al(2'b11, 0, 2, 1, 2'b01), 4, 1, 16'hFFFB, 0, 0);
    v(mi(4, 8'h40), 2, 0, 0, 0, 0);
    v(ms(5, 4, 2'b10), 4, 1, 16'h0020, 0, 0);
    v(mi(7, 8'hFF), 2, 0, 0, 0, 0);
    v(al(2'b11, 0, 5, 7, 0), 4, 1, 16'h0000, 0, 0);
    v(mi(3, 8'h80), 2, 0, 0, 0, 0);
    v(ms(0, 3, 0), 4, 1, 16'hFF80, 0, 0);
    v(16'h0000, 1, 1, 16'hFF80, 0, 0);
    v(16'hD800, 1, 1, 16'hFF80, 0, 0);
    v(ms(6, 7, 0), 4, 1, 16'hFFFF, 1, 3'b001);
    @(negedge clk); @(negedge clk);
    check("rst_w", {15'd0, w}, 16'h0001);
    check("rst_out", out, 16'h0000);
    check("rst_flags", {13'd0, Z, N, V}, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < vec.size(); i++) begin
      sb.push_back(vec[i]);
      run(vec[i].instr, n);
      e = sb.pop_front();
      check($sformatf("lat[%0d]", i), n[15:0], e.lat[15:0]);
      if (e.chk_out) check($sformatf("out[%0d]", i), out, e.exp_out);
      if (e.chk_f) check($sformatf("flags[%0d]", i), {13'd0, Z, N, V}, {13'd0, e.exp_f});
    end
    run(mi(1, 8'd3), n);
    run(mi(2, 8'd4), n);
    @(negedge clk); in = al(2'b00, 1, 5, 2, 0); load = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b1;
    @(negedge clk); s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_w", {15'd0, w}, 16'h0000);
    reset = 1'b1;
    #1;
    check("mid_rst_w", {15'd0, w}, 16'h0001);
    check("mid_rst_out", out, 16'h0000);
    check("mid_rst_flags", {13'd0, Z, N, V}, 16'h0000);
    @(negedge clk); reset = 1'b0;
    sb.push_back('{al(2'b11, 0, 0, 5, 0), 4, 1, 16'hFFFF, 0, 0});
    run(sb[0].instr, n);
    e = sb.pop_front();
    check("post_rst_lat", n[15:0], e.lat[15:0]);
    check("post_rst_r5", out, e.exp_out);
    run(ms(0, 1, 0), n);
    check("post_rst_r1", out, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
